// File: rtl/keypad_pkg.sv
// keypad_pkg: shared types and helpers for the 4x4 keypad front end.
// Holds FSM state encoding, scan-result kinds, and key-code mapping.
package keypad_pkg;

    localparam int unsigned NUM_ROWS  = 4;
    localparam int unsigned NUM_COLS  = 4;
    localparam int unsigned ROW_W     = 2;
    localparam int unsigned COL_W     = 2;
    localparam int unsigned KEY_W     = ROW_W + COL_W;
    localparam int unsigned SCAN_BITS = NUM_ROWS * NUM_COLS;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_DEBOUNCE = 2'd1,
        ST_PRESSED  = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        SCAN_NONE   = 2'd0,
        SCAN_SINGLE = 2'd1,
        SCAN_MULTI  = 2'd2
    } scan_kind_t;

    // Key code as seen by the calculator core: {row_idx, col_idx}.
    typedef struct packed {
        logic [ROW_W-1:0] row;
        logic [COL_W-1:0] col;
    } key_code_t;

    typedef struct packed {
        scan_kind_t kind;
        key_code_t  key;
    } scan_result_t;

    // Corner keys of the matrix, used by the core for layout lookups.
    localparam key_code_t KEY_R0C0 = '{row: 2'd0, col: 2'd0};
    localparam key_code_t KEY_R0C3 = '{row: 2'd0, col: 2'd3};
    localparam key_code_t KEY_R3C0 = '{row: 2'd3, col: 2'd0};
    localparam key_code_t KEY_R3C3 = '{row: 2'd3, col: 2'd3};

    // Classify a full-scan bitmap; bit (row*4 + col) maps directly to the key code.
    function automatic scan_result_t classify_scan(input logic [SCAN_BITS-1:0] bits);
        scan_result_t res;
        int unsigned  n_set;
        res.kind = SCAN_NONE;
        res.key  = KEY_R0C0;
        n_set    = 0;
        for (int i = 0; i < SCAN_BITS; i++) begin
            if (bits[i]) begin
                n_set   = n_set + 1;
                res.key = key_code_t'(KEY_W'(i));
            end
        end
        if (n_set == 1) begin
            res.kind = SCAN_SINGLE;
        end else if (n_set > 1) begin
            res.kind = SCAN_MULTI;
        end
        return res;
    endfunction

endpackage

// File: rtl/keypad_row_timer.sv
// keypad_row_timer: dwell counter and one-hot row drive for the keypad sweep.
// Ports:
//   i_clk, i_rst      clock, async active-high reset
//   o_row_idx         currently driven row (0..3)
//   o_row_sweep       one-hot row drive, registered
//   o_sample_en_c     high on the last dwell cycle of every row
//   o_scan_end_c      high on the last dwell cycle of row 3
module keypad_row_timer
    import keypad_pkg::*;
#(
    parameter int unsigned ROW_CYCLES = 1024
) (
    input  logic                i_clk,
    input  logic                i_rst,
    output logic [ROW_W-1:0]    o_row_idx,
    output logic [NUM_ROWS-1:0] o_row_sweep,
    output logic                o_sample_en_c,
    output logic                o_scan_end_c
);

    localparam int unsigned     DW         = $clog2(ROW_CYCLES);
    localparam logic [DW-1:0]   DWELL_LAST = DW'(ROW_CYCLES - 1);

    logic [DW-1:0]       r_dwell;
    logic [ROW_W-1:0]    r_row_idx;
    logic [NUM_ROWS-1:0] r_row_sweep;
    logic                w_last;

    assign w_last = (r_dwell == DWELL_LAST);

    // Row sweep is kept as a rotating one-hot register alongside the index.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_dwell     <= '0;
            r_row_idx   <= '0;
            r_row_sweep <= NUM_ROWS'(1);
        end else if (w_last) begin
            r_dwell     <= '0;
            r_row_idx   <= r_row_idx + 1'b1;
            r_row_sweep <= {r_row_sweep[NUM_ROWS-2:0], r_row_sweep[NUM_ROWS-1]};
        end else begin
            r_dwell     <= r_dwell + 1'b1;
        end
    end

    assign o_row_idx     = r_row_idx;
    assign o_row_sweep   = r_row_sweep;
    assign o_sample_en_c = w_last;
    assign o_scan_end_c  = w_last && (r_row_idx == ROW_W'(NUM_ROWS - 1));

endmodule

// File: rtl/keypad_scanner.sv
// keypad_scanner: scans a 4x4 keypad, debounces, and emits one key_valid
// pulse with key_code per accepted press.
// Ports:
//   clk, rst     clock, async active-high reset
//   col_in       raw active-high column lines (asynchronous)
//   row_sweep    one-hot active-high row drive
//   key_valid    single-cycle pulse per accepted press
//   key_code     {row, col} of last accepted key, held between pulses
//   key_held     high while the accepted key is still down
module keypad_scanner
    import keypad_pkg::*;
#(
    parameter int unsigned ROW_CYCLES   = 1024,
    parameter int unsigned DEBOUNCE_CNT = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NUM_COLS-1:0] col_in,
    output logic [NUM_ROWS-1:0] row_sweep,
    output logic                key_valid,
    output logic [KEY_W-1:0]    key_code,
    output logic                key_held
);

    localparam int unsigned   CW         = $clog2(DEBOUNCE_CNT + 1);
    localparam logic [CW-1:0] CNT_TARGET = CW'(DEBOUNCE_CNT);

    logic [ROW_W-1:0]     w_row_idx;
    logic                 w_sample_en;
    logic                 w_scan_end;

    logic [NUM_COLS-1:0]  r_sync1;
    logic [NUM_COLS-1:0]  r_sync2;
    logic [SCAN_BITS-NUM_COLS-1:0] r_acc;
    logic [SCAN_BITS-1:0] w_scan_bits;
    scan_result_t         w_scan;

    state_t               r_state,     w_state_n;
    logic [CW-1:0]        r_cnt,       w_cnt_n;
    logic [CW-1:0]        w_cnt_inc;
    key_code_t            r_cand,      w_cand_n;
    key_code_t            r_key_code,  w_key_code_n;
    logic                 r_key_valid, w_key_valid_n;
    logic                 r_key_held,  w_key_held_n;

    keypad_row_timer #(
        .ROW_CYCLES (ROW_CYCLES)
    ) u_row_timer (
        .i_clk         (clk),
        .i_rst         (rst),
        .o_row_idx     (w_row_idx),
        .o_row_sweep   (row_sweep),
        .o_sample_en_c (w_sample_en),
        .o_scan_end_c  (w_scan_end)
    );

    // Two-flop synchronizer for the asynchronous column lines.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= col_in;
            r_sync2 <= r_sync1;
        end
    end

    // Rows 0..2 are stored; row 3 is taken live from the synchronizer at scan end.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_acc <= '0;
        end else if (w_sample_en) begin
            case (w_row_idx)
                2'd0:    r_acc[3:0]  <= r_sync2;
                2'd1:    r_acc[7:4]  <= r_sync2;
                2'd2:    r_acc[11:8] <= r_sync2;
                default: ;
            endcase
        end
    end

    assign w_scan_bits = {r_sync2, r_acc};
    assign w_scan      = classify_scan(w_scan_bits);
    assign w_cnt_inc   = (r_cnt == CNT_TARGET) ? r_cnt : r_cnt + 1'b1;

    // FSM state and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_cnt       <= '0;
            r_cand      <= KEY_R0C0;
            r_key_code  <= KEY_R0C0;
            r_key_valid <= 1'b0;
            r_key_held  <= 1'b0;
        end else begin
            r_state     <= w_state_n;
            r_cnt       <= w_cnt_n;
            r_cand      <= w_cand_n;
            r_key_code  <= w_key_code_n;
            r_key_valid <= w_key_valid_n;
            r_key_held  <= w_key_held_n;
        end
    end

    // Next-state logic, stepped only at scan end.
    always_comb begin
        w_state_n     = r_state;
        w_cnt_n       = r_cnt;
        w_cand_n      = r_cand;
        w_key_code_n  = r_key_code;
        w_key_valid_n = 1'b0;

        if (w_scan_end) begin
            case (r_state)
                ST_IDLE: begin
                    if (w_scan.kind == SCAN_SINGLE) begin
                        w_cand_n = w_scan.key;
                        if (DEBOUNCE_CNT == 1) begin
                            w_state_n     = ST_PRESSED;
                            w_cnt_n       = '0;
                            w_key_valid_n = 1'b1;
                            w_key_code_n  = w_scan.key;
                        end else begin
                            w_state_n = ST_DEBOUNCE;
                            w_cnt_n   = CW'(1);
                        end
                    end
                end
                ST_DEBOUNCE: begin
                    if (w_scan.kind == SCAN_SINGLE && w_scan.key == r_cand) begin
                        if (w_cnt_inc == CNT_TARGET) begin
                            w_state_n     = ST_PRESSED;
                            w_cnt_n       = '0;
                            w_key_valid_n = 1'b1;
                            w_key_code_n  = r_cand;
                        end else begin
                            w_cnt_n = w_cnt_inc;
                        end
                    end else begin
                        w_state_n = ST_IDLE;
                        w_cnt_n   = '0;
                    end
                end
                ST_PRESSED: begin
                    // Release needs DEBOUNCE_CNT consecutive empty scans; any key activity restarts it.
                    if (w_scan.kind == SCAN_NONE) begin
                        if (w_cnt_inc == CNT_TARGET) begin
                            w_state_n = ST_IDLE;
                            w_cnt_n   = '0;
                        end else begin
                            w_cnt_n = w_cnt_inc;
                        end
                    end else begin
                        w_cnt_n = '0;
                    end
                end
                default: begin
                    w_state_n = ST_IDLE;
                    w_cnt_n   = '0;
                end
            endcase
        end

        w_key_held_n = (w_state_n == ST_PRESSED);
    end

    assign key_valid = r_key_valid;
    assign key_code  = r_key_code;
    assign key_held  = r_key_held;

endmodule
